// File: rtl/os_array_sequencer.sv
// os_array_sequencer: output-stationary PE array tile sequencer; define OS_SEQ_FI_EN for fault-injection sequencing
module os_array_sequencer #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int K_WIDTH = 8,
  localparam int CNT_W = K_WIDTH + 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [K_WIDTH-1:0] k_len,
  output logic               busy,
  output logic               done,
  output logic               array_rst,
  output logic               fsm_op2_select,
  output logic               stat_bit,
  output logic               fsm_out_select,
  output logic [CNT_W-1:0]   feed_cnt,
  output logic [ROWS-1:0]    row_feed_en,
  output logic [COLS-1:0]    col_feed_en,
  output logic               drain_valid,
  output logic [2:0]         drain_row
`ifdef OS_SEQ_FI_EN
  ,
  input  logic               fi_arm,
  input  logic               fi_type,
  input  logic [CNT_W-1:0]   fi_cycle,
  output logic [1:0]         fault_inject
`endif
);
  typedef enum logic [2:0] {IDLE, CLEAR, COMPUTE, DRAIN, DONE} state_t;
  state_t state, ns;
  logic [K_WIDTH-1:0] k_q;
  logic [CNT_W-1:0] cnt_n, kx, last;
  logic [2:0] drow_n;
  logic [ROWS-1:0] row_n;
  logic [COLS-1:0] col_n;
  assign fsm_op2_select = 1'b0;
  assign stat_bit = 1'b0;
  assign kx = CNT_W'(k_q);
  assign last = kx + CNT_W'(ROWS + COLS - 2);
  // next state plus next values of every registered output; abort wins in the busy states
  always_comb begin
    ns = state;
    row_n = '0;
    col_n = '0;
    case (state)
      IDLE:    ns = start ? CLEAR : IDLE;
      CLEAR:   ns = abort ? IDLE : (k_q == '0 ? DRAIN : COMPUTE);
      COMPUTE: ns = abort ? IDLE : (feed_cnt == last ? DRAIN : COMPUTE);
      DRAIN:   ns = abort ? IDLE : (drain_row == 3'd0 ? DONE : DRAIN);
      default: ns = IDLE;
    endcase
    cnt_n = (state == COMPUTE && ns == COMPUTE) ? feed_cnt + CNT_W'(1) : '0;
    drow_n = ns != DRAIN ? 3'd0 : state == DRAIN ? drain_row - 3'd1 : 3'(ROWS - 1);
    for (int r = 0; r < ROWS; r++)
      row_n[r] = ns == COMPUTE && cnt_n >= CNT_W'(r) && cnt_n < CNT_W'(r) + kx;
    for (int c = 0; c < COLS; c++)
      col_n[c] = ns == COMPUTE && cnt_n >= CNT_W'(c) && cnt_n < CNT_W'(c) + kx;
  end
  // state, captured tile length and all registered outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      k_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      array_rst <= 1'b0;
      fsm_out_select <= 1'b0;
      drain_valid <= 1'b0;
      feed_cnt <= '0;
      drain_row <= 3'd0;
      row_feed_en <= '0;
      col_feed_en <= '0;
    end else begin
      state <= ns;
      if (state == IDLE && start) k_q <= k_len;
      busy <= ns inside {CLEAR, COMPUTE, DRAIN};
      done <= ns == DONE;
      array_rst <= ns == CLEAR;
      fsm_out_select <= ns == DRAIN;
      drain_valid <= ns == DRAIN;
      feed_cnt <= cnt_n;
      drain_row <= drow_n;
      row_feed_en <= row_n;
      col_feed_en <= col_n;
    end
`ifdef OS_SEQ_FI_EN
  logic arm_q, type_q;
  logic [CNT_W-1:0] fic_q;
  // fault request captured at start, fired on the matching COMPUTE cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      arm_q <= 1'b0;
      type_q <= 1'b0;
      fic_q <= '0;
      fault_inject <= 2'b00;
    end else begin
      if (state == IDLE && start) begin
        arm_q <= fi_arm;
        type_q <= fi_type;
        fic_q <= fi_cycle;
      end
      fault_inject <= (ns == COMPUTE && arm_q && cnt_n == fic_q) ? {type_q, 1'b1} : 2'b00;
    end
`endif
endmodule

// File: tb/tb_os_array_sequencer.sv
// tb_os_array_sequencer: random and directed checks against a tile-timeline model
module tb_os_array_sequencer;
  localparam int ROWS = 4, COLS = 4, K_WIDTH = 8, CNT_W = K_WIDTH + 4;
  logic clk = 0, rst = 1, start = 0, abort = 0;
  logic [K_WIDTH-1:0] k_len = '0;
  logic busy, done, array_rst, fsm_op2_select, stat_bit, fsm_out_select, drain_valid;
  logic [CNT_W-1:0] feed_cnt;
  logic [ROWS-1:0] row_feed_en;
  logic [COLS-1:0] col_feed_en;
  logic [2:0] drain_row;
`ifdef OS_SEQ_FI_EN
  logic fi_arm = 0, fi_type = 0;
  logic [CNT_W-1:0] fi_cycle = '0;
  logic [1:0] fault_inject;
`endif
  int errors = 0, checks = 0;
  int off = 0, mk = 0;
  bit m_arm, m_type;
  int m_fic;

  os_array_sequencer #(.ROWS(ROWS), .COLS(COLS), .K_WIDTH(K_WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .k_len(k_len),
    .busy(busy), .done(done), .array_rst(array_rst), .fsm_op2_select(fsm_op2_select),
    .stat_bit(stat_bit), .fsm_out_select(fsm_out_select), .feed_cnt(feed_cnt),
    .row_feed_en(row_feed_en), .col_feed_en(col_feed_en), .drain_valid(drain_valid),
    .drain_row(drain_row)
`ifdef OS_SEQ_FI_EN
    , .fi_arm(fi_arm), .fi_type(fi_type), .fi_cycle(fi_cycle), .fault_inject(fault_inject)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // first DRAIN offset from the start edge: CLEAR at 1, COMPUTE k+ROWS+COLS-1 cycles if k>0
  function automatic int dstart(int k);
    return k > 0 ? k + ROWS + COLS + 1 : 2;
  endfunction

  // model: off = cycles since the accepted start edge, 0 when idle
  always @(posedge clk or posedge rst)
    if (rst) off <= 0;
    else if (off == 0) begin
      if (start) begin
        off <= 1;
        mk <= int'(k_len);
`ifdef OS_SEQ_FI_EN
        m_arm <= fi_arm;
        m_type <= fi_type;
        m_fic <= int'(fi_cycle);
`endif
      end
    end else if (off >= dstart(mk) + ROWS || abort) off <= 0;
    else off <= off + 1;

  // compare every cycle against the timeline
  always @(negedge clk) begin
    bit inc, ind;
    int fc, ds;
    logic [ROWS-1:0] er;
    logic [COLS-1:0] ec;
    ds = dstart(mk);
    inc = off >= 2 && off < ds;
    ind = off >= ds && off < ds + ROWS;
    fc = inc ? off - 2 : 0;
    for (int r = 0; r < ROWS; r++) er[r] = inc && fc >= r && fc < r + mk;
    for (int c = 0; c < COLS; c++) ec[c] = inc && fc >= c && fc < c + mk;
    chk("busy", busy, off > 0 && off < ds + ROWS);
    chk("done", done, off > 0 && off == ds + ROWS);
    chk("array_rst", array_rst, off == 1);
    chk("out_sel", fsm_out_select, ind);
    chk("drain_valid", drain_valid, ind);
    chk("drain_row", drain_row, ind ? ROWS - 1 - (off - ds) : 0);
    chk("feed_cnt", feed_cnt, fc);
    chk("row_feed_en", row_feed_en, er);
    chk("col_feed_en", col_feed_en, ec);
    chk("op2_stat", {fsm_op2_select, stat_bit}, 0);
`ifdef OS_SEQ_FI_EN
    chk("fault_inject", fault_inject, (inc && m_arm && fc == m_fic) ? {m_type, 1'b1} : 2'b00);
`endif
  end

  // run a tile of length k for 20 cycles and summarise what the outputs did
  task automatic observe(input int k, output int rc, output int fcyc, output int nc,
                         output int rm, output int cm, output int dsq, output int dc, output int nd);
    rc = 0; fcyc = 0; nc = 0; rm = 0; cm = 0; dsq = 0; dc = 0; nd = 0;
    @(negedge clk);
    #1 k_len = K_WIDTH'(k); start = 1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (array_rst) rc = c;
      if (busy && !array_rst && !drain_valid) begin
        nc++;
        if (fcyc == 0) fcyc = c;
      end
      if (row_feed_en[2]) rm |= 1 << feed_cnt;
      if (col_feed_en[0]) cm |= 1 << feed_cnt;
      if (drain_valid) dsq = (dsq << 4) | int'(drain_row);
      if (done) begin dc = c; nd++; end
      #1 start = 0; k_len = K_WIDTH'($urandom_range(0, 255));
    end
  endtask

  initial begin
    int rc, fcyc, nc, rm, cm, dsq, dc, nd, n;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_outs", {done, array_rst, drain_valid, fsm_out_select, drain_row, row_feed_en, col_feed_en}, 0);
    chk("reset_feed_cnt", feed_cnt, 0);
    #1 rst = 0;
    observe(3, rc, fcyc, nc, rm, cm, dsq, dc, nd);
    chk("k3_array_rst_cycle", rc, 1);
    chk("k3_first_compute", fcyc, 2);
    chk("k3_compute_cycles", nc, 10);
    chk("k3_row2_feed", rm, 32'h1c);
    chk("k3_col0_feed", cm, 32'h7);
    chk("k3_drain_seq", dsq, 32'h3210);
    chk("k3_done_cycle", dc, 16);
    observe(0, rc, fcyc, nc, rm, cm, dsq, dc, nd);
    chk("k0_compute_cycles", nc, 0);
    chk("k0_row2_feed", rm, 0);
    chk("k0_done_cycle", dc, 6);
    // abort at feed_cnt 5, restart one cycle later
    @(negedge clk);
    #1 k_len = 8'd5; start = 1;
    @(negedge clk);
    #1 start = 0;
    for (n = 0; n < 30 && feed_cnt != 5; n++) @(negedge clk);
    chk("abort_reach_fc5", n < 30, 1);
    #1 abort = 1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    #1 abort = 0; start = 1; k_len = 8'd2;
    @(negedge clk);
    chk("abort_restart", array_rst, 1);
    #1 start = 0;
    repeat (16) @(negedge clk);
    // asynchronous reset during DRAIN
    #1 k_len = 8'd1; start = 1;
    @(negedge clk);
    #1 start = 0;
    for (n = 0; n < 30 && !drain_valid; n++) @(negedge clk);
    chk("rst_reach_drain", n < 30, 1);
    #1 rst = 1;
    #1 chk("rst_async_outs", {busy, drain_valid, fsm_out_select, drain_row, done}, 0);
    @(negedge clk);
    #1 rst = 0;
    // start while busy is ignored
    @(negedge clk);
    #1 k_len = 8'd2; start = 1;
    @(negedge clk);
    #1 start = 0;
    repeat (2) @(negedge clk);
    #1 start = 1; k_len = 8'd6;
    nd = 0; rc = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (done) nd++;
      if (array_rst) rc++;
      #1 start = 0;
    end
    chk("busy_start_done_count", nd, 1);
    chk("busy_start_no_clear", rc, 0);
`ifdef OS_SEQ_FI_EN
    fi_arm = 1; fi_type = 1; fi_cycle = CNT_W'(4);
    @(negedge clk);
    #1 k_len = 8'd3; start = 1;
    nd = 0; rc = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fault_inject == 2'b11) begin nd++; rc = int'(feed_cnt); end
      #1 start = 0; fi_arm = 0;
    end
    chk("fi_pulse_count", nd, 1);
    chk("fi_pulse_fc", rc, 4);
`endif
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      start = $urandom_range(0, 3) == 0;
      k_len = K_WIDTH'($urandom_range(0, 7));
      abort = $urandom_range(0, 39) == 0;
      rst = $urandom_range(0, 299) == 0;
`ifdef OS_SEQ_FI_EN
      fi_arm = 1'($urandom_range(0, 1));
      fi_type = 1'($urandom_range(0, 1));
      fi_cycle = CNT_W'($urandom_range(0, 16));
`endif
    end
    @(negedge clk);
    #1 rst = 0; start = 0; abort = 0;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
